memoria_dados_resp: RTL

- Data-memory responder that sits opposite the multicycle control unit.
- Accepts one-cycle read/write request strobes (ld/sd step 2) with address and write data from the ALU_OUT and B registers.
- Performs the access against an internal word array after a programmable number of wait states.
- Returns read data plus a one-cycle READY pulse, which the control unit uses to leave its memory-wait state.

---
 rtl/mem_pkg.sv | 19 +
 rtl/ram_sincrona.sv | 42 ++++
 rtl/memoria_dados_resp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, operation kind and
// doubleword offset width.
package mem_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ACESSO,
    RESPONDE
  } estado_mem_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_mem_t;

  // Low address bits that select a byte within a doubleword.
  localparam int unsigned BYTE_OFS = 3;

endpackage

// File: rtl/ram_sincrona.sv
// Single-port word array with synchronous write enable and a registered read
// port; the read register resets to zero, the array itself is never cleared.
module ram_sincrona #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memoria_dados_resp.sv
// Data-memory responder: accepts one-cycle ld/sd strobes, waits LAT cycles and
// pulses READY. Optional MEM_ALIGN_CHK_EN flags misaligned accesses on ERR.
module memoria_dados_resp
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned LAT    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_RD,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              READY,
  output logic              BUSY,
  output logic              ERR
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  estado_mem_t       state_d, state_q;
  logic [3:0]        cnt_d, cnt_q;
  op_mem_t           op_d, op_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              mis_d, mis_q;
  logic              ready_d, ready_q;
  logic              busy_d, busy_q;
  logic              err_d, err_q;
  logic              mis_req;
  logic              ram_we, ram_re;
  logic              unused_addr;

`ifdef MEM_ALIGN_CHK_EN
  assign mis_req = (ADDR[BYTE_OFS-1:0] != '0);
`else
  assign mis_req = 1'b0;
`endif

  // Upper address bits alias into the array; low bits only matter to the checker.
  assign unused_addr = ^ADDR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (REQ_WR || REQ_RD) begin
          op_d    = REQ_WR ? OP_WR : OP_RD;
          idx_d   = ADDR[IdxW+BYTE_OFS-1:BYTE_OFS];
          wdata_d = WR_DATA;
          mis_d   = mis_req;
          cnt_d   = 4'(LAT - 1);
          state_d = ACESSO;
        end
      end
      ACESSO: begin
        if (cnt_q == '0) begin
          state_d = RESPONDE;
          ready_d = 1'b1;
          err_d   = mis_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPONDE: state_d = OCIOSO;
      default:  state_d = OCIOSO;
    endcase
    busy_d = (state_d != OCIOSO);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Read is strobed on the edge entering RESPONDE so RD_DATA is valid with READY;
  // the write commits on the edge leaving RESPONDE.
  assign ram_we = (state_q == RESPONDE) && (op_q == OP_WR) && !mis_q;
  assign ram_re = (state_q == ACESSO) && (cnt_q == '0) && (op_q == OP_RD) && !mis_q;

  ram_sincrona #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (CLK),
    .rst_ni (RST),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(RD_DATA)
  );

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign ERR   = err_q;

endmodule
